// File: rtl/byte_striping.sv
// rtl/byte_striping.sv - two-lane word striper: pairs consecutive valid words onto lane 0/lane 1
// A lone lane-0 word is flushed by itself after FLUSH_CYCLES idle input cycles.
module byte_striping #(
    parameter int DATA_WIDTH   = 32,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic                  clk_2f,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] lane_0,
    output logic [DATA_WIDTH-1:0] lane_1,
    output logic                  valid_0,
    output logic                  valid_1,
    output logic                  pending
);
    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   hold_reg;
    logic [CNT_W-1:0]        idle_cnt;

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            state    <= EMPTY;
            hold_reg <= '0;
            idle_cnt <= '0;
            lane_0   <= '0;
            lane_1   <= '0;
            valid_0  <= 1'b0;
            valid_1  <= 1'b0;
        end else begin
            valid_0 <= 1'b0;
            valid_1 <= 1'b0;
            case (state)
                EMPTY: begin
                    if (valid_in) begin
                        hold_reg <= data_in;
                        idle_cnt <= '0;
                        state    <= HALF;
                    end
                end
                HALF: begin
                    // A word arriving on the would-be flush cycle still completes the pair.
                    if (valid_in) begin
                        lane_0   <= hold_reg;
                        lane_1   <= data_in;
                        valid_0  <= 1'b1;
                        valid_1  <= 1'b1;
                        idle_cnt <= '0;
                        state    <= EMPTY;
                    end else if (idle_cnt == FLUSH_LAST) begin
                        lane_0   <= hold_reg;
                        lane_1   <= '0;
                        valid_0  <= 1'b1;
                        idle_cnt <= '0;
                        state    <= EMPTY;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign pending = (state == HALF);
endmodule

// File: tb/tb_byte_striping.sv
// tb/tb_byte_striping.sv - self-checking bench for byte_striping against a queue-based reference model
module tb_byte_striping;
    localparam int DW    = 32;
    localparam int FLUSH = 4;

    logic          clk_2f = 1'b0;
    logic          reset;
    logic [DW-1:0] data_in;
    logic          valid_in;
    logic [DW-1:0] lane_0, lane_1;
    logic          valid_0, valid_1, pending;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] held_q[$];
    int            idle_seen;
    logic [DW-1:0] m_lane_0, m_lane_1;
    logic          m_v0, m_v1;
    logic [DW-1:0] sent_q[$];
    logic [DW-1:0] got_q[$];
    int            pair_strobes;

    byte_striping #(.DATA_WIDTH(DW), .FLUSH_CYCLES(FLUSH)) dut (
        .clk_2f  (clk_2f),
        .reset   (reset),
        .data_in (data_in),
        .valid_in(valid_in),
        .lane_0  (lane_0),
        .lane_1  (lane_1),
        .valid_0 (valid_0),
        .valid_1 (valid_1),
        .pending (pending)
    );

    always #5 clk_2f = ~clk_2f;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid_0"}, {31'b0, valid_0}, {31'b0, m_v0});
        check({tag, ".valid_1"}, {31'b0, valid_1}, {31'b0, m_v1});
        check({tag, ".lane_0"}, lane_0, m_lane_0);
        check({tag, ".lane_1"}, lane_1, m_lane_1);
        check({tag, ".pending"}, {31'b0, pending}, {31'b0, (held_q.size() != 0)});
    endtask

    task automatic model_reset();
        held_q.delete();
        sent_q.delete();
        got_q.delete();
        idle_seen = 0;
        m_lane_0 = '0;
        m_lane_1 = '0;
        m_v0 = 1'b0;
        m_v1 = 1'b0;
    endtask

    // One clock: drive inputs, advance the model by the striping rules, compare.
    task automatic cycle(input string tag, input logic v, input logic [DW-1:0] d);
        valid_in = v;
        data_in  = d;
        @(posedge clk_2f);
        #1;
        m_v0 = 1'b0;
        m_v1 = 1'b0;
        if (v) sent_q.push_back(d);
        if (held_q.size() == 0) begin
            if (v) begin
                held_q.push_back(d);
                idle_seen = 0;
            end
        end else if (v) begin
            m_lane_0 = held_q.pop_front();
            m_lane_1 = d;
            m_v0 = 1'b1;
            m_v1 = 1'b1;
        end else begin
            idle_seen++;
            if (idle_seen == FLUSH) begin
                m_lane_0 = held_q.pop_front();
                m_lane_1 = '0;
                m_v0 = 1'b1;
            end
        end
        if (valid_0) got_q.push_back(lane_0);
        if (valid_1) got_q.push_back(lane_1);
        if (valid_0 && valid_1) pair_strobes++;
        check_all(tag);
        valid_in = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = '0;
        model_reset();
        pair_strobes = 0;
        repeat (2) @(posedge clk_2f);
        #1;
        check_all("por");
        reset = 1'b0;

        // Mid-stream reset discards the held word immediately
        cycle("rst_pre", 1'b1, 32'h0BAD0BAD);
        check("rst_pend", {31'b0, pending}, 32'd1);
        reset = 1'b1;
        #1;
        model_reset();
        check_all("rst_async");
        @(posedge clk_2f);
        #1;
        reset = 1'b0;
        cycle("rst_a", 1'b1, 32'h11111111);
        cycle("rst_b", 1'b1, 32'h22222222);
        check("rst_pair_l0", lane_0, 32'h11111111);
        check("rst_pair_l1", lane_1, 32'h22222222);
        cycle("rst_after", 1'b0, '0);

        // Back-to-back stream
        pair_strobes = 0;
        for (int i = 0; i < 8; i++) cycle("b2b", 1'b1, 32'hA0000000 + i);
        cycle("b2b_idle", 1'b0, '0);
        check("b2b_pairs", pair_strobes, 32'd4);

        // Gap of FLUSH-1 idles inside a pair
        cycle("gap_a", 1'b1, 32'h5);
        for (int i = 0; i < FLUSH - 1; i++) cycle("gap_idle", 1'b0, '0);
        cycle("gap_b", 1'b1, 32'h6);
        check("gap_l0", lane_0, 32'h5);
        check("gap_l1", lane_1, 32'h6);

        // Odd tail flush
        cycle("fl_a", 1'b1, 32'hDEADBEEF);
        for (int i = 0; i < FLUSH; i++) cycle("fl_idle", 1'b0, '0);
        check("fl_v0", {31'b0, valid_0}, 32'd1);
        check("fl_l0", lane_0, 32'hDEADBEEF);
        check("fl_l1", lane_1, 32'h0);
        check("fl_pend", {31'b0, pending}, 32'd0);
        cycle("fl_after", 1'b0, '0);

        // Valid word on the would-be flush cycle
        cycle("race_a", 1'b1, 32'h12345678);
        for (int i = 0; i < FLUSH - 1; i++) cycle("race_idle", 1'b0, '0);
        cycle("race_b", 1'b1, 32'hCAFE0001);
        check("race_v1", {31'b0, valid_1}, 32'd1);
        check("race_l1", lane_1, 32'hCAFE0001);

        // Random words with random gaps; output stream must reproduce input order
        sent_q.delete();
        got_q.delete();
        cycle("rnd_pre", 1'b0, '0);
        for (int i = 0; i < 100; i++) begin
            cycle("rnd_word", 1'b1, $urandom);
            for (int g = 0, n = $urandom_range(0, 6); g < n; g++) cycle("rnd_idle", 1'b0, '0);
        end
        for (int i = 0; i < FLUSH + 1; i++) cycle("rnd_tail", 1'b0, '0);
        check("stream_len", got_q.size(), 32'd100);
        for (int i = 0; i < 100 && i < got_q.size(); i++) check("stream_word", got_q[i], sent_q[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
